touch_led_multi: RTL and testbench
==================================

// Module: touch_led_multi
// PURPOSE
//  Multi-channel touch-key to LED controller; successor to single-key toggle design.
//  Per channel: 2-FF synchroniser, press/release debounce FSM, edge pulses, selectable
//  toggle/follow LED mode. Sits between board touch pads and LED pins / status logic.
// PARAMETERS
//  CH_NUM    4           number of independent key/LED channels (>=1)
//  DEB_CNT   1_000_000   stable cycles required to accept press/release (20 ms @ 50 MHz); >=2
//  LONG_CNT  50_000_000  held cycles after press accept to flag long press (1 s); >DEB_CNT
// PORTS
//  sys_clk      in   1        system clock, rising edge
//  sys_rst_n    in   1        asynchronous active-low reset
//  touch_key    in   CH_NUM   raw async touch pad outputs, 1 = touched
//  mode         in   CH_NUM   per channel: 0 = toggle, 1 = follow (LED mirrors debounced key)
//  led          out  CH_NUM   LED drive, 1 = on
//  key_press    out  CH_NUM   1-cycle pulse on accepted press
//  key_release  out  CH_NUM   1-cycle pulse on accepted release
//  long_press   out  CH_NUM   1-cycle pulse on long hold (0 when feature compiled out)
// BEHAVIOUR
//  - Reset (async on sys_rst_n=0, any state): led, key_press, key_release, long_press = 0;
//    sync FFs = 0; FSM = IDLE; counters = 0. Release is synchronous to sys_clk.
//  - Sync: key_s = touch_key delayed 2 FFs; FSM sees key_s only.
//  - FSM per channel, counter cnt width $clog2(max(DEB_CNT,LONG_CNT)):
//    IDLE:  key_s=1 -> DEB_P, cnt=0.
//    DEB_P: key_s=0 -> IDLE; else cnt++; at cnt==DEB_CNT-1 -> PRESSED, cnt=0, key_press=1.
//    PRESSED: key_s=0 -> DEB_R, cnt=0; else cnt++ (saturates at LONG_CNT-1).
//    DEB_R: key_s=1 -> PRESSED (cnt keeps held count, no new press pulse);
//           else cnt++; at cnt==DEB_CNT-1 -> IDLE, key_release=1.
//  - Latency: touch_key high from sampling edge 1, stable -> key_press high after edge DEB_CNT+3.
//    Release symmetric: key_release high after edge DEB_CNT+3 from first low sample.
//  - Glitch shorter than DEB_CNT cycles (post-sync) never produces a pulse or LED change.
//  - LED, toggle mode: led inverts on the same edge key_press asserts; unchanged on release.
//  - LED, follow mode: led=1 while FSM in PRESSED or DEB_R, 0 in IDLE or DEB_P
//    (updated on the same edges as key_press / key_release).
//  - mode change mid-press: new mode applies next edge; toggle->follow forces led to follow
//    value; follow->toggle holds current led.
//  - Channels fully independent; simultaneous presses on several channels all accepted
//    on their own edges, no priority.
//  - key_press/key_release/long_press are registered, high exactly one cycle.
// CONFIGURATION
//  TOUCH_LONG_PRESS_EN defined: in PRESSED, when cnt reaches LONG_CNT-1 -> long_press=1
//    one cycle, once per press (re-arm on return to IDLE); in toggle mode also clears led
//    to 0 on that edge; follow mode led unaffected. Bounce in DEB_R does not re-arm.
//  Not defined: long_press tied 0, no long-hold counting beyond debounce; PRESSED cnt idle.
// TESTING (bench overrides DEB_CNT=4, LONG_CNT=20, CH_NUM=2, 20 ns clock)
//  1 reset 200 ns, key0 high 2000 ns, low -> key_press[0] pulse 7th edge after rise,
//    led[0] 0->1; key_release[0] 7th edge after fall; second press -> led[0] 1->0.
//  2 key0 high 3 cycles then low (glitch) -> no pulses, led[0] stays 0.
//  3 mode[1]=1, key1 held 40 cycles -> led[1]=1 from press pulse edge until release pulse.
//  4 TOUCH_LONG_PRESS_EN, toggle, key0 held 40 cycles -> press (led=1), long_press[0] once
//    after 20 accepted-held cycles, led[0]=0; without macro long_press stays 0, led=1.
//  5 both keys pressed on same cycle -> key_press[1:0]=2'b11 on same edge, both leds toggle.
//  6 assert sys_rst_n=0 while key0 in DEB_P and PRESSED -> all outputs 0 immediately;
//    after release with key still held -> full debounce again, fresh key_press.

Source files
------------

// File: rtl/touch_led_multi.sv
// Multi-channel touch-key to LED controller: per channel 2-FF synchroniser, debounce FSM,
// press/release pulses and toggle/follow LED. Define TOUCH_LONG_PRESS_EN for long-press detection.
module touch_led_multi #(
    parameter int CH_NUM   = 4,
    parameter int DEB_CNT  = 1_000_000,
    parameter int LONG_CNT = 50_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [CH_NUM-1:0] touch_key,
    input  logic [CH_NUM-1:0] mode,
    output logic [CH_NUM-1:0] led,
    output logic [CH_NUM-1:0] key_press,
    output logic [CH_NUM-1:0] key_release,
    output logic [CH_NUM-1:0] long_press
);

    localparam int CNT_MAX = (LONG_CNT > DEB_CNT) ? LONG_CNT : DEB_CNT;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DEB_P   = 2'd1,
        PRESSED = 2'd2,
        DEB_R   = 2'd3
    } state_t;

    logic [CH_NUM-1:0] sync1_q;
    logic [CH_NUM-1:0] key_s_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= '0;
            key_s_q <= '0;
        end else begin
            sync1_q <= touch_key;
            key_s_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi = gi + 1) begin : ch_g
            state_t        state_q, state_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          led_q, led_d;
            logic          press_q, press_d;
            logic          rel_q, rel_d;
`ifdef TOUCH_LONG_PRESS_EN
            localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
            // Held count lives apart from the debounce count so a release bounce keeps it.
            logic [CW-1:0] hold_q, hold_d;
            logic          fired_q, fired_d;
            logic          long_q, long_d;
`endif

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                press_d = 1'b0;
                rel_d   = 1'b0;
`ifdef TOUCH_LONG_PRESS_EN
                hold_d  = hold_q;
                fired_d = fired_q;
                long_d  = 1'b0;
`endif
                case (state_q)
                    IDLE: begin
`ifdef TOUCH_LONG_PRESS_EN
                        hold_d  = '0;
                        fired_d = 1'b0;
`endif
                        if (key_s_q[gi]) begin
                            state_d = DEB_P;
                            cnt_d   = '0;
                        end
                    end
                    DEB_P: begin
                        if (!key_s_q[gi]) begin
                            state_d = IDLE;
                        end else if (cnt_q == DEB_LAST) begin
                            state_d = PRESSED;
                            cnt_d   = '0;
                            press_d = 1'b1;
`ifdef TOUCH_LONG_PRESS_EN
                            hold_d  = '0;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!key_s_q[gi]) begin
                            state_d = DEB_R;
                            cnt_d   = '0;
                        end
`ifdef TOUCH_LONG_PRESS_EN
                        else if (hold_q == LONG_LAST) begin
                            if (!fired_q) begin
                                long_d  = 1'b1;
                                fired_d = 1'b1;
                            end
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
`endif
                    end
                    DEB_R: begin
                        if (key_s_q[gi]) begin
                            state_d = PRESSED;
                        end else if (cnt_q == DEB_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            rel_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase

                // Follow mode tracks the next state, so a mode switch takes effect on the next edge.
                if (mode[gi]) begin
                    led_d = (state_d == PRESSED) || (state_d == DEB_R);
                end else begin
                    led_d = led_q ^ press_d;
`ifdef TOUCH_LONG_PRESS_EN
                    if (long_d) begin
                        led_d = 1'b0;
                    end
`endif
                end
            end

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    led_q   <= 1'b0;
                    press_q <= 1'b0;
                    rel_q   <= 1'b0;
`ifdef TOUCH_LONG_PRESS_EN
                    hold_q  <= '0;
                    fired_q <= 1'b0;
                    long_q  <= 1'b0;
`endif
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    led_q   <= led_d;
                    press_q <= press_d;
                    rel_q   <= rel_d;
`ifdef TOUCH_LONG_PRESS_EN
                    hold_q  <= hold_d;
                    fired_q <= fired_d;
                    long_q  <= long_d;
`endif
                end
            end

            assign led[gi]         = led_q;
            assign key_press[gi]   = press_q;
            assign key_release[gi] = rel_q;
`ifdef TOUCH_LONG_PRESS_EN
            assign long_press[gi]  = long_q;
`else
            assign long_press[gi]  = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_touch_led_multi.sv
// Bench for touch_led_multi: directed table, hand-written latency/reset sequences and
// randomized key activity checked every cycle against a run-length reference model.
module tb_touch_led_multi;

    localparam int CH   = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;
`ifdef TOUCH_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [CH-1:0] touch_key = '0;
    logic [CH-1:0] mode      = '0;
    logic [CH-1:0] led, key_press, key_release, long_press;

    int checks   = 0;
    int failures = 0;

    touch_led_multi #(.CH_NUM(CH), .DEB_CNT(DEB), .LONG_CNT(LONG)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .touch_key  (touch_key),
        .mode       (mode),
        .led        (led),
        .key_press  (key_press),
        .key_release(key_release),
        .long_press (long_press)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a key flips its debounced level after DEB+1 consecutive
    // synchronised samples that disagree with it; held time counts agreeing samples.
    logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_ks = '0;
    logic [CH-1:0] m_led = '0, m_press = '0, m_rel = '0, m_long = '0;
    bit            m_deb[CH];
    int            m_run[CH];
    int            m_held[CH];
    bit            m_fired[CH];

    initial begin
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) begin
                m_s1 = '0; m_s2 = '0;
                m_led = '0; m_press = '0; m_rel = '0; m_long = '0;
                for (int c = 0; c < CH; c++) begin
                    m_deb[c] = 1'b0; m_run[c] = 0; m_held[c] = 0; m_fired[c] = 1'b0;
                end
            end else begin
                m_ks = m_s2;
                m_s2 = m_s1;
                m_s1 = touch_key;
                m_press = '0; m_rel = '0; m_long = '0;
                for (int c = 0; c < CH; c++) begin
                    if (m_ks[c] != m_deb[c]) begin
                        m_run[c]++;
                        if (m_run[c] == DEB + 1) begin
                            m_deb[c] = m_ks[c];
                            m_run[c] = 0;
                            if (m_ks[c]) begin
                                m_press[c] = 1'b1;
                                m_held[c]  = 0;
                            end else begin
                                m_rel[c]   = 1'b1;
                                m_fired[c] = 1'b0;
                            end
                        end
                    end else begin
                        if (LP_EN && m_deb[c] && m_run[c] == 0) begin
                            if (m_held[c] == LONG - 1) begin
                                if (!m_fired[c]) begin
                                    m_long[c]  = 1'b1;
                                    m_fired[c] = 1'b1;
                                end
                            end else begin
                                m_held[c]++;
                            end
                        end
                        m_run[c] = 0;
                    end
                    if (mode[c]) begin
                        m_led[c] = m_deb[c];
                    end else begin
                        if (m_press[c]) m_led[c] = ~m_led[c];
                        if (m_long[c])  m_led[c] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            check("cycle_model", {24'd0, led, key_press, key_release, long_press},
                  {24'd0, m_led, m_press, m_rel, m_long});
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        touch_key = '0;
        mode      = '0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] key;
        logic [1:0] mode;
        int         high;
        logic [1:0] exp_press;
        logic [1:0] exp_rel;
        logic [1:0] exp_long;
        logic [1:0] exp_led;
    } vec_t;

    vec_t vecs[10];
    int   pc[CH], rc[CH], lc[CH];
    int   run_left[CH];

    initial begin
        vecs[0] = '{2'b01, 2'b00,  3, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[1] = '{2'b01, 2'b00,  4, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[2] = '{2'b01, 2'b00,  5, 2'b01, 2'b01, 2'b00, 2'b01};
        vecs[3] = '{2'b11, 2'b00, 10, 2'b11, 2'b11, 2'b00, 2'b11};
        vecs[4] = '{2'b10, 2'b10, 10, 2'b10, 2'b10, 2'b00, 2'b00};
        vecs[5] = '{2'b01, 2'b00, 40, 2'b01, 2'b01, LP_EN ? 2'b01 : 2'b00, LP_EN ? 2'b00 : 2'b01};
        vecs[6] = '{2'b11, 2'b11, 40, 2'b11, 2'b11, LP_EN ? 2'b11 : 2'b00, 2'b00};
        vecs[7] = '{2'b11, 2'b01, 40, 2'b11, 2'b11, LP_EN ? 2'b11 : 2'b00, LP_EN ? 2'b00 : 2'b10};
        vecs[8] = '{2'b01, 2'b00, 24, 2'b01, 2'b01, 2'b00, 2'b01};
        vecs[9] = '{2'b01, 2'b00, 25, 2'b01, 2'b01, LP_EN ? 2'b01 : 2'b00, LP_EN ? 2'b00 : 2'b01};

        // Reset state
        #200;
        @(negedge sys_clk);
        check("reset_outputs", {28'd0, led, key_press}, 32'd0);
        sys_rst_n = 1'b1;
        tick();
        check("reset_after_release", {24'd0, led, key_press, key_release, long_press}, 32'd0);

        // Press latency, release latency, second press toggles back
        do_reset();
        touch_key[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) check("t1_press_edge6", key_press[0], 0);
        end
        check("t1_press_edge7", key_press[0], 1);
        check("t1_led_on", led[0], 1);
        repeat (93) tick();
        touch_key[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) check("t1_release_edge6", key_release[0], 0);
        end
        check("t1_release_edge7", key_release[0], 1);
        check("t1_led_hold_on_release", led[0], 1);
        repeat (10) tick();
        touch_key[0] = 1'b1;
        repeat (7) tick();
        check("t1_second_press", key_press[0], 1);
        check("t1_led_off", led[0], 0);
        touch_key[0] = 1'b0;
        repeat (15) tick();

        // Table-driven vectors, each from reset
        for (int i = 0; i < 10; i++) begin
            do_reset();
            mode = vecs[i].mode;
            for (int c = 0; c < CH; c++) begin
                pc[c] = 0; rc[c] = 0; lc[c] = 0;
            end
            touch_key = vecs[i].key;
            for (int t = 0; t < vecs[i].high + 20; t++) begin
                if (t == vecs[i].high) touch_key = '0;
                tick();
                for (int c = 0; c < CH; c++) begin
                    pc[c] += int'(key_press[c]);
                    rc[c] += int'(key_release[c]);
                    lc[c] += int'(long_press[c]);
                end
            end
            for (int c = 0; c < CH; c++) begin
                check($sformatf("vec%0d_ch%0d_press", i, c), pc[c], vecs[i].exp_press[c]);
                check($sformatf("vec%0d_ch%0d_release", i, c), rc[c], vecs[i].exp_rel[c]);
                check($sformatf("vec%0d_ch%0d_long", i, c), lc[c], vecs[i].exp_long[c]);
            end
            check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
        end

        // Asynchronous reset in DEB_P and in PRESSED
        do_reset();
        touch_key[0] = 1'b1;
        repeat (4) tick();
        #3 sys_rst_n = 1'b0;
        #1 check("t6_rst_debp", {24'd0, led, key_press, key_release, long_press}, 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (10) tick();
        check("t6_led_pressed", led[0], 1);
        #3 sys_rst_n = 1'b0;
        #1 check("t6_rst_pressed", {24'd0, led, key_press, key_release, long_press}, 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) check("t6_fresh_press_edge6", key_press[0], 0);
        end
        check("t6_fresh_press_edge7", key_press[0], 1);
        check("t6_fresh_led", led[0], 1);
        touch_key[0] = 1'b0;
        repeat (15) tick();

        // Randomized key activity with occasional mode flips
        do_reset();
        for (int c = 0; c < CH; c++) run_left[c] = 0;
        for (int t = 0; t < 2000; t++) begin
            for (int c = 0; c < CH; c++) begin
                if (run_left[c] == 0) begin
                    touch_key[c] = ~touch_key[c];
                    if ($urandom_range(0, 5) == 0) run_left[c] = int'($urandom_range(24, 45));
                    else run_left[c] = int'($urandom_range(1, 12));
                end
                run_left[c]--;
                if ($urandom_range(0, 60) == 0) mode[c] = ~mode[c];
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
